// File: rtl/sram_master.sv
// Burst master for a single-port synchronous SRAM with 1-cycle read latency.
// Write bursts stream incrementing address/data; read bursts return one beat per handshake.
module sram_master #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, WR, RD_WAIT, RD_CAP, RD_RESP} state_t;

  state_t              state_q;
  logic [1:0]          cnt_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_last_q;

  logic [ADDR_W-1:0]   addr_inc_d;
  logic [DATA_W-1:0]   wdata_inc_d;
  logic                last_beat_d;

  assign addr_inc_d  = mem_addr_q + ADDR_W'(1);
  assign wdata_inc_d = mem_wdata_q + DATA_W'(1);
  assign last_beat_d = (cnt_q == 2'd0);

  // Held low during reset so nothing is accepted on the reset edge itself.
  assign req_ready = (state_q == IDLE) && !rst;

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_last  = rsp_last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            mem_addr_q <= req_addr;
            cnt_q      <= req_len;
            if (req_we) begin
              mem_we_q    <= 1'b1;
              mem_wdata_q <= req_wdata;
              state_q     <= WR;
            end else begin
              mem_we_q <= 1'b0;
              state_q  <= RD_WAIT;
            end
          end
        end
        WR: begin
          if (last_beat_d) begin
            mem_we_q <= 1'b0;
            state_q  <= IDLE;
          end else begin
            mem_addr_q  <= addr_inc_d;
            mem_wdata_q <= wdata_inc_d;
            cnt_q       <= cnt_q - 2'd1;
          end
        end
        // The SRAM samples mem_addr at the end of RD_WAIT; data is valid during RD_CAP.
        RD_WAIT: state_q <= RD_CAP;
        RD_CAP: begin
          rsp_rdata_q <= mem_rdata;
          rsp_valid_q <= 1'b1;
          rsp_last_q  <= last_beat_d;
          state_q     <= RD_RESP;
        end
        RD_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (last_beat_d) begin
              state_q <= IDLE;
            end else begin
              mem_addr_q <= addr_inc_d;
              cnt_q      <= cnt_q - 2'd1;
              state_q    <= RD_WAIT;
            end
          end
        end
        default: begin
          mem_we_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_master.sv
// Directed bench for sram_master with a behavioural 16x8 SRAM (1-cycle registered read).
module tb_sram_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [3:0] req_addr;
  logic [1:0] req_len;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_last;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic       preload;
  logic [7:0] sram [16];

  sram_master #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_last(rsp_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Location i preloads to 0x10+i so untouched cells are recognisable.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) sram[i] <= 8'(8'h10 + i);
    end else begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      mem_rdata <= sram[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Read burst with rsp_ready held high; exp holds beat b in byte b.
  // With hold_next set, req_valid stays high offering a write of 0x33 to addr 8.
  task automatic rd_burst(input string tag, input logic [3:0] addr, input logic [1:0] len,
                          input logic [31:0] exp, input bit hold_next);
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_len = len; rsp_ready = 1'b1;
    tick();
    chk({tag, "_acc_addr"}, 32'(mem_addr), 32'(addr));
    chk({tag, "_acc_ready"}, 32'(req_ready), 32'd0);
    if (hold_next) begin
      req_we = 1'b1; req_addr = 4'd8; req_wdata = 8'h33; req_len = 2'd0;
    end else begin
      req_valid = 1'b0;
    end
    for (int b = 0; b <= int'(len); b++) begin
      int n;
      n = 0;
      do begin
        tick();
        n++;
        chk({tag, "_busy_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_busy_we"}, 32'(mem_we), 32'd0);
      end while (!rsp_valid && n < 8);
      chk({tag, "_lat"}, 32'(n), 32'd2);
      chk({tag, "_data"}, 32'(rsp_rdata), 32'(exp[8*b +: 8]));
      chk({tag, "_last"}, 32'(rsp_last), 32'(b == int'(len)));
      tick();
      chk({tag, "_vld_drop"}, 32'(rsp_valid), 32'd0);
    end
  endtask

  initial begin
    int n;
    preload = 1'b1;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
    req_wdata = '0; rsp_ready = 1'b0;
    tick();
    preload = 1'b0;
    tick();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_last", 32'(rsp_last), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_ready", 32'(req_ready), 32'd1);
    tick();

    // Single write of 0xA5 to addr 3, then read it back.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd3; req_wdata = 8'hA5; req_len = 2'd0;
    tick();
    req_valid = 1'b0;
    chk("w1_we", 32'(mem_we), 32'd1);
    chk("w1_addr", 32'(mem_addr), 32'd3);
    chk("w1_wdata", 32'(mem_wdata), 32'hA5);
    chk("w1_ready", 32'(req_ready), 32'd0);
    tick();
    chk("w1_we_off", 32'(mem_we), 32'd0);
    chk("w1_ready_back", 32'(req_ready), 32'd1);
    chk("w1_sram3", 32'(sram[3]), 32'hA5);
    rd_burst("r1", 4'd3, 2'd0, 32'h0000_00A5, 1'b0);
    chk("r1_idle", 32'(req_ready), 32'd1);

    // Four-beat write wrapping from addr 14 to addr 1.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd14; req_wdata = 8'hFE; req_len = 2'd3;
    tick();
    req_valid = 1'b0;
    chk("w4_b0_we", 32'(mem_we), 32'd1);
    chk("w4_b0", 32'({mem_addr, mem_wdata}), 32'h0E_FE);
    tick();
    chk("w4_b1_we", 32'(mem_we), 32'd1);
    chk("w4_b1", 32'({mem_addr, mem_wdata}), 32'h0F_FF);
    tick();
    chk("w4_b2_we", 32'(mem_we), 32'd1);
    chk("w4_b2", 32'({mem_addr, mem_wdata}), 32'h00_00);
    tick();
    chk("w4_b3_we", 32'(mem_we), 32'd1);
    chk("w4_b3", 32'({mem_addr, mem_wdata}), 32'h01_01);
    tick();
    chk("w4_we_off", 32'(mem_we), 32'd0);
    chk("w4_sram", 32'({sram[14], sram[15], sram[0], sram[1]}), 32'hFEFF_0001);
    chk("w4_sram2_untouched", 32'(sram[2]), 32'h12);
    rd_burst("r4", 4'd14, 2'd3, 32'h0100_FFFE, 1'b0);

    // Backpressure: two-beat read from 14 with rsp_ready low for 5 cycles.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd14; req_len = 2'd1; rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!rsp_valid && n < 8);
    chk("bp_lat0", 32'(n), 32'd2);
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold", 32'({rsp_valid, rsp_last, rsp_rdata}), 32'h2FE);
      chk("bp_addr", 32'(mem_addr), 32'd14);
      chk("bp_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_hs_vld", 32'(rsp_valid), 32'd0);
    chk("bp_hs_addr", 32'(mem_addr), 32'd15);
    n = 0;
    do begin tick(); n++; end while (!rsp_valid && n < 8);
    chk("bp_lat1", 32'(n), 32'd2);
    chk("bp_beat1", 32'({rsp_valid, rsp_last, rsp_rdata}), 32'h3FF);
    rsp_ready = 1'b1;
    tick();
    chk("bp_done", 32'({req_ready, rsp_valid}), 32'b10);

    // Request held during a 4-beat read from addr 0; accepted only once idle.
    rd_burst("busy", 4'd0, 2'd3, 32'hA512_0100, 1'b1);
    chk("busy_ready_after", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk("busy_acc", 32'({mem_we, mem_addr, mem_wdata}), 32'h1_8_33);
    tick();
    chk("busy_we_off", 32'(mem_we), 32'd0);
    chk("busy_sram8", 32'(sram[8]), 32'h33);

    // Reset during beat 2 of a 4-beat write at addr 4.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd4; req_wdata = 8'h70; req_len = 2'd3;
    tick();
    req_valid = 1'b0;
    tick();
    chk("rw_beat2", 32'({mem_we, mem_addr, mem_wdata}), 32'h1_5_71);
    rst = 1'b1;
    tick();
    chk("rw_we", 32'(mem_we), 32'd0);
    chk("rw_addr", 32'(mem_addr), 32'd0);
    chk("rw_ready_in_rst", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rw_ready_rel", 32'(req_ready), 32'd1);
    tick();
    tick();
    chk("rw_we_quiet", 32'(mem_we), 32'd0);
    chk("rw_sram", 32'({sram[4], sram[5], sram[6], sram[7]}), 32'h7071_1617);

    // Reset while a read response is pending.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3; req_len = 2'd3; rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!rsp_valid && n < 8);
    chk("rr_resp", 32'({rsp_valid, rsp_rdata}), 32'h1A5);
    rst = 1'b1;
    tick();
    chk("rr_outs", 32'({rsp_valid, rsp_last, rsp_rdata, mem_we, mem_addr, mem_wdata}), 32'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("rr_quiet", 32'({rsp_valid, mem_we, req_ready}), 32'b001);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
